// File: rtl/mem_arbiter_if.sv
// Request/response bus between the IF/MEM pipeline stages, the arbiter and the SRAM pads.
// The slave modport is the arbiter; the master modport is the pipeline plus SRAM side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        stall_if;
  logic        stall_mem;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_wdata_oe;
  logic [31:0] sram_rdata;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, sram_rdata,
    output if_rdata, if_valid, mem_rdata, mem_valid, stall_if, stall_mem,
           sram_addr, sram_wdata, sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, sram_rdata,
    input  if_rdata, if_valid, mem_rdata, mem_valid, stall_if, stall_mem,
           sram_addr, sram_wdata, sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port asynchronous SRAM arbiter: MEM stage has fixed priority over instruction fetch.
// Strobes are registered from the next state so pads change cleanly on clock edges.
module mem_arbiter #(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AW     = 20;
  localparam int unsigned DW     = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD, RESP} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;   // 1 = MEM owns the SRAM, 0 = IF
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               ce_n_q, oe_n_q, we_n_q, woe_q;
  logic               ce_n_d, oe_n_d, we_n_d, woe_d;
  logic [SEL_W-1:0]   be_n_q, be_n_d;
  logic [DW-1:0]      if_rdata_q, mem_rdata_q;
  logic               if_valid_q, mem_valid_q;
  logic               if_valid_d, mem_valid_d;
  logic               capture_c;

  // Last wait cycle of a read: sample the pad into the owner's data register
  assign capture_c = (state_q == READ) && (cnt_q == '0);

  // Next-state, grant latching and next values of the registered strobes
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          owner_d = 1'b1;
          addr_d  = bus.mem_addr[21:2];
          wdata_d = bus.mem_wdata;
          sel_d   = bus.mem_sel;
          if (bus.mem_we) begin
            state_d = WSETUP;
          end else begin
            state_d = READ;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end else if (bus.if_req) begin
          owner_d = 1'b0;
          addr_d  = bus.if_addr[21:2];
          state_d = READ;
          cnt_d   = CNT_W'(RD_WAIT - 1);
        end
      end
      READ: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WSETUP: begin
        state_d = WPULSE;
        cnt_d   = CNT_W'(WR_PULSE - 1);
      end
      WPULSE: begin
        if (cnt_q == '0) state_d = WHOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WHOLD:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ce_n_d      = !(state_d inside {READ, WSETUP, WPULSE, WHOLD});
    oe_n_d      = (state_d != READ);
    we_n_d      = (state_d != WPULSE);
    woe_d       = (state_d inside {WSETUP, WPULSE, WHOLD});
    if_valid_d  = (state_d == RESP) && !owner_d;
    mem_valid_d = (state_d == RESP) && owner_d;
    if (state_d == READ)  be_n_d = '0;
    else if (woe_d)       be_n_d = ~sel_d;
    else                  be_n_d = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      woe_q       <= 1'b0;
      be_n_q      <= '1;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      woe_q       <= woe_d;
      be_n_q      <= be_n_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      if (capture_c && owner_q)  mem_rdata_q <= bus.sram_rdata;
      if (capture_c && !owner_q) if_rdata_q  <= bus.sram_rdata;
    end
  end

  assign bus.sram_addr     = addr_q;
  assign bus.sram_wdata    = wdata_q;
  assign bus.sram_wdata_oe = woe_q;
  assign bus.sram_ce_n     = ce_n_q;
  assign bus.sram_oe_n     = oe_n_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_be_n     = be_n_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.if_valid      = if_valid_q;
  assign bus.mem_valid     = mem_valid_q;

  // Stalls release in the same cycle the registered valid pulse appears
  assign bus.stall_if  = bus.if_req  & ~if_valid_q;
  assign bus.stall_mem = bus.mem_req & ~mem_valid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-timing instance (a) and slow-timing instance (b).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if a_bus ();
  mem_arbiter_if b_bus ();

  mem_arbiter #(.RD_WAIT(1), .WR_PULSE(1)) u_a (.clk(clk), .rst(rst), .bus(a_bus.slave));
  mem_arbiter #(.RD_WAIT(3), .WR_PULSE(2)) u_b (.clk(clk), .rst(rst), .bus(b_bus.slave));

  // SRAM content model: one special word, otherwise a tag plus the word address
  function automatic logic [31:0] sram_model(input logic [19:0] a);
    if (a == 20'h00004) return 32'h2402_0001;
    return {12'h5A5, a};
  endfunction

  assign a_bus.sram_rdata = sram_model(a_bus.sram_addr);
  assign b_bus.sram_rdata = sram_model(b_bus.sram_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-cycle activity counters sampled mid-cycle
  int a_stall_if = 0, a_stall_mem = 0, a_oe_low = 0, a_we_low = 0, a_woe = 0;
  int a_ifv = 0, a_memv = 0, a_overlap = 0, b_oe_low = 0, b_we_low = 0;
  logic [3:0] a_be_wr = 4'hF;
  always @(negedge clk) begin
    if (a_bus.stall_if)  a_stall_if++;
    if (a_bus.stall_mem) a_stall_mem++;
    if (!a_bus.sram_oe_n) a_oe_low++;
    if (!a_bus.sram_we_n) begin a_we_low++; a_be_wr = a_bus.sram_be_n; end
    if (a_bus.sram_wdata_oe) a_woe++;
    if (a_bus.if_valid)  a_ifv++;
    if (a_bus.mem_valid) a_memv++;
    if (!a_bus.sram_oe_n && !a_bus.sram_we_n) a_overlap++;
    if (!b_bus.sram_oe_n) b_oe_low++;
    if (!b_bus.sram_we_n) b_we_low++;
  end

  int s_stall_if, s_stall_mem, s_oe, s_we, s_woe, s_ifv, s_memv;
  int mlat, ilat;

  task automatic snap();
    s_stall_if = a_stall_if; s_stall_mem = a_stall_mem; s_oe = a_oe_low;
    s_we = a_we_low; s_woe = a_woe; s_ifv = a_ifv; s_memv = a_memv;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fixed window on instance a: record first valid cycle, drop each request after its valid
  task automatic run_a(input int n, output int ml, output int il);
    ml = 99; il = 99;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_bus.mem_valid && ml == 99) ml = i;
      if (a_bus.if_valid && il == 99)  il = i;
      @(posedge clk); #1;
      if (ml != 99) a_bus.mem_req = 1'b0;
      if (il != 99) a_bus.if_req  = 1'b0;
    end
  endtask

  task automatic run_b(input int n, output int ml, output int il);
    ml = 99; il = 99;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (b_bus.mem_valid && ml == 99) ml = i;
      if (b_bus.if_valid && il == 99)  il = i;
      @(posedge clk); #1;
      if (ml != 99) b_bus.mem_req = 1'b0;
      if (il != 99) b_bus.if_req  = 1'b0;
    end
  endtask

  initial begin
    logic found;
    a_bus.if_req = 0; a_bus.if_addr = '0; a_bus.mem_req = 0; a_bus.mem_we = 0;
    a_bus.mem_addr = '0; a_bus.mem_wdata = '0; a_bus.mem_sel = '0;
    b_bus.if_req = 0; b_bus.if_addr = '0; b_bus.mem_req = 0; b_bus.mem_we = 0;
    b_bus.mem_addr = '0; b_bus.mem_wdata = '0; b_bus.mem_sel = '0;
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ce_n", 32'(a_bus.sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(a_bus.sram_oe_n), 32'd1);
    check("rst_we_n", 32'(a_bus.sram_we_n), 32'd1);
    check("rst_be_n", 32'(a_bus.sram_be_n), 32'hF);
    check("rst_wdata_oe", 32'(a_bus.sram_wdata_oe), 32'd0);
    check("rst_sram_addr", 32'(a_bus.sram_addr), 32'd0);
    check("rst_valids", 32'({a_bus.if_valid, a_bus.mem_valid}), 32'd0);
    check("rst_rdata", a_bus.if_rdata | a_bus.mem_rdata, 32'd0);

    // IF read, default timing
    idle(1); snap();
    a_bus.if_addr = 32'h8000_0010; a_bus.if_req = 1'b1;
    run_a(6, mlat, ilat);
    idle(2);
    check("if_rd_lat", 32'(ilat), 32'd2);
    check("if_rd_data", a_bus.if_rdata, 32'h2402_0001);
    check("if_rd_addr", 32'(a_bus.sram_addr), 32'h00004);
    check("if_rd_stall", 32'(a_stall_if - s_stall_if), 32'd2);
    check("if_rd_oe_cycles", 32'(a_oe_low - s_oe), 32'd1);
    check("if_rd_pulses", 32'(a_ifv - s_ifv), 32'd1);
    check("if_rd_mem_rdata", a_bus.mem_rdata, 32'd0);

    // MEM byte write to the top byte
    snap();
    a_bus.mem_addr = 32'h8000_0103; a_bus.mem_sel = 4'b1000;
    a_bus.mem_wdata = 32'hAB00_0000; a_bus.mem_we = 1'b1; a_bus.mem_req = 1'b1;
    run_a(8, mlat, ilat);
    idle(2);
    check("wr_lat", 32'(mlat), 32'd4);
    check("wr_be_n", 32'(a_be_wr), 32'b0111);
    check("wr_we_cycles", 32'(a_we_low - s_we), 32'd1);
    check("wr_woe_cycles", 32'(a_woe - s_woe), 32'd3);
    check("wr_oe_cycles", 32'(a_oe_low - s_oe), 32'd0);
    check("wr_addr", 32'(a_bus.sram_addr), 32'h00040);
    check("wr_wdata", a_bus.sram_wdata, 32'hAB00_0000);
    check("wr_pulses", 32'(a_memv - s_memv), 32'd1);

    // Contention: MEM read and IF read raised together
    snap();
    a_bus.mem_we = 1'b0; a_bus.mem_addr = 32'h0000_0020; a_bus.if_addr = 32'h0000_0040;
    a_bus.mem_req = 1'b1; a_bus.if_req = 1'b1;
    run_a(10, mlat, ilat);
    idle(2);
    check("cont_mem_lat", 32'(mlat), 32'd2);
    check("cont_if_lat", 32'(ilat), 32'd5);
    check("cont_mem_data", a_bus.mem_rdata, 32'h5A50_0008);
    check("cont_if_data", a_bus.if_rdata, 32'h5A50_0010);
    check("cont_stall_if", 32'(a_stall_if - s_stall_if), 32'd5);
    check("cont_stall_mem", 32'(a_stall_mem - s_stall_mem), 32'd2);

    // IF request dropped right after grant still completes once
    snap();
    a_bus.if_addr = 32'h0000_0100; a_bus.if_req = 1'b1;
    idle(1);
    a_bus.if_req = 1'b0;
    run_a(6, mlat, ilat);
    check("drop_lat", 32'(ilat), 32'd1);
    check("drop_pulses", 32'(a_ifv - s_ifv), 32'd1);
    check("drop_data", a_bus.if_rdata, 32'h5A50_0040);
    check("drop_idle_ce_n", 32'(a_bus.sram_ce_n), 32'd1);

    // Reset in the middle of the write pulse
    snap();
    a_bus.mem_addr = 32'h0000_0008; a_bus.mem_sel = 4'hF;
    a_bus.mem_wdata = 32'h1234_5678; a_bus.mem_we = 1'b1; a_bus.mem_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!a_bus.sram_we_n) begin found = 1'b1; break; end
    end
    check("rst_wpulse_seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_bus.mem_req = 1'b0;
    @(negedge clk);
    check("rstw_we_n", 32'(a_bus.sram_we_n), 32'd1);
    check("rstw_woe", 32'(a_bus.sram_wdata_oe), 32'd0);
    check("rstw_be_n", 32'(a_bus.sram_be_n), 32'hF);
    check("rstw_ce_n", 32'(a_bus.sram_ce_n), 32'd1);
    idle(4);
    check("rstw_no_valid", 32'(a_memv - s_memv), 32'd0);

    snap();
    a_bus.mem_addr = 32'h0000_000C; a_bus.mem_sel = 4'b0011;
    a_bus.mem_wdata = 32'hCAFE_F00D; a_bus.mem_req = 1'b1;
    run_a(8, mlat, ilat);
    idle(2);
    check("fresh_wr_lat", 32'(mlat), 32'd4);
    check("fresh_wr_be_n", 32'(a_be_wr), 32'b1100);
    check("fresh_wr_pulses", 32'(a_memv - s_memv), 32'd1);
    check("no_oe_we_overlap", 32'(a_overlap), 32'd0);

    // Slow instance: RD_WAIT=3, WR_PULSE=2
    s_oe = b_oe_low;
    b_bus.if_addr = 32'h0000_0080; b_bus.if_req = 1'b1;
    run_b(8, mlat, ilat);
    idle(2);
    check("slow_rd_lat", 32'(ilat), 32'd4);
    check("slow_rd_oe_cycles", 32'(b_oe_low - s_oe), 32'd3);
    check("slow_rd_data", b_bus.if_rdata, 32'h5A50_0020);

    s_we = b_we_low;
    b_bus.mem_addr = 32'h0000_0004; b_bus.mem_sel = 4'hF;
    b_bus.mem_wdata = 32'h0BAD_BEEF; b_bus.mem_we = 1'b1; b_bus.mem_req = 1'b1;
    run_b(10, mlat, ilat);
    idle(2);
    check("slow_wr_lat", 32'(mlat), 32'd5);
    check("slow_wr_we_cycles", 32'(b_we_low - s_we), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
